pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Owns the fetch program counter for the 3-stage CPU (Fetch / Decode-Execute / Writeback). It resolves EX-stage branch and jump outcomes into the next PC, squashes wrong-path instructions, and honours hazard stalls. It also detects the HALT idiom, consecutive 0x00000000 fetches. It sits between the control unit/ALU and the instruction memory address port, replacing the ad-hoc pc_next logic in the top level.

Parameters:
PC_W, 12, word-address width of the PC (4K-word instruction memory)
RESET_PC, 12'd0, PC value loaded on reset
HALT_ZEROS, 2, number of consecutive unflushed 0x00000000 instructions in F that enter HALTED (range 1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
stall_in  in  1  hazard stall: hold PC and halt counter
instr_F  in  32  instruction currently held in the fetch register
br_valid_EX  in  1  EX stage holds a control-transfer instruction
pcsrc_EX  in  2  00 SEQ, 01 BRANCH, 10 JAL, 11 JALR
br_taken_EX  in  1  branch condition result; used only when pcsrc_EX=BRANCH
br_target_EX  in  PC_W  word target for BRANCH/JAL (pc_EX + imm>>2)
jalr_target_EX  in  32  byte target rs1+imm for JALR
resume  in  1  leave HALTED
pc  out  PC_W  fetch word address
flush_F  out  1  squash the instruction in F (convert it to a bubble before EX)
halted  out  1  high while in HALTED
misalign_err  out  1  one-cycle pulse: JALR target bits[1:0] != 0

Behaviour:
- Reset: synchronous, active-high. pc=RESET_PC, state=RUN, zero_cnt=0, flush_F=0, halted=0, misalign_err=0.
- States: RUN, FLUSH, HALTED.
- Redirect condition in RUN: br_valid_EX & (pcsrc_EX==JAL | pcsrc_EX==JALR | (pcsrc_EX==BRANCH & br_taken_EX)).
- Redirect target:
  - BRANCH/JAL: br_target_EX.
  - JALR: jalr_target_EX[PC_W+1:2] (bit 0 cleared per ISA).
  - JALR with jalr_target_EX[1:0]!=0 also pulses misalign_err the next cycle; the redirect still occurs.
- RUN, redirect in cycle t:
  - flush_F=1 combinationally in cycle t (squashes the instruction at the branch address +1).
  - At edge t+1: pc<=target, state<=FLUSH, zero_cnt<=0.
- FLUSH, one cycle: flush_F=1 (squashes the instruction at branch address +2), branch inputs ignored, pc<=pc+1 unless stall_in, state<=RUN.
- RUN, no redirect: pc<=pc+1 unless stall_in; pc holds on stall.
- pc wraps modulo 2^PC_W (0xFFF+1 -> 0x000); no error is flagged.
- Simultaneous redirect and stall_in: redirect wins. The branch is older than the hazard, so the redirect is taken and the stall is ignored that cycle.
- Halt detection, in RUN only:
  - zero_cnt increments when instr_F==0, flush_F==0 and stall_in==0.
  - Any nonzero unflushed instruction clears zero_cnt to 0.
  - zero_cnt saturates at 15.
  - When zero_cnt reaches HALT_ZEROS: state<=HALTED, pc frozen.
- Redirect in the same cycle as the final zero: redirect wins, zero_cnt clears, no halt.
- HALTED: halted=1, flush_F=1 (pipeline fed bubbles), pc held, stall/branch inputs ignored. resume=1 -> state<=RUN, zero_cnt<=0, pc<=pc+1.
- Reset while in FLUSH or HALTED returns to the reset values in one cycle.
- Latency: a redirect affects the pc seen by fetch one cycle after EX resolution. The branch penalty is 2 squashed instructions.

Optional Feature:
Macro PC_SEQ_PERF_EN.
- Defined: adds outputs redirect_cnt (32), flush_cnt (32) and stall_cnt (32).
  - Free-running counters that increment on redirect, on each flush_F cycle, and on each stalled cycle respectively.
  - All counters clear on rst and wrap at 2^32.
- Undefined: these ports and their registers do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package cpu_pkg:
  - enum pcsrc_e {PCSRC_SEQ=2'b00, PCSRC_BRANCH=2'b01, PCSRC_JAL=2'b10, PCSRC_JALR=2'b11}.
  - enum pcseq_state_e {PCS_RUN, PCS_FLUSH, PCS_HALTED}.
  - Constants INSTR_HALT=32'h0000_0000 and IMEM_AW=12.
- One sub-module: halt_detect.
  - Contains zero_cnt and its compare against HALT_ZEROS.
  - Inputs: instr_F, flush_F, stall_in, clear.
  - Output: halt_hit.

Test Plan:
1. Reset, then 5 cycles of sequential fetch -> pc = 0,1,2,3,4,5; flush_F=0 throughout.
2. In RUN, with pc=0x010, drive BRANCH, br_taken_EX=1, br_target_EX=0x040 -> flush_F=1 for 2 cycles, next pc=0x040 then 0x041.
3. Drive JALR with jalr_target_EX=0x0000_0106 -> pc=0x041, misalign_err pulses once, 2 flush cycles.
4. Assert stall_in for 3 cycles at pc=0x020, with a JAL to 0x100 on the 2nd stalled cycle -> pc holds at 0x020 for 1 cycle, then becomes 0x100.
5. Feed instr_F=0x00000000 twice, unflushed, with HALT_ZEROS=2 -> halted=1, pc frozen. Pulse resume -> halted=0, pc increments by 1.
6. Set pc=0xFFF with no stall -> pc wraps to 0x000. Assert rst during FLUSH -> pc=RESET_PC, flush_F=0 the next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC-source and sequencer state encodings, halt idiom, imem width.
package cpu_pkg;

   localparam int          IMEM_AW    = 12;
   localparam logic [31:0] INSTR_HALT = 32'h0000_0000;

   typedef enum logic [1:0] {
      PCSRC_SEQ    = 2'b00,
      PCSRC_BRANCH = 2'b01,
      PCSRC_JAL    = 2'b10,
      PCSRC_JALR   = 2'b11
   } pcsrc_e;

   typedef enum logic [1:0] {
      PCS_RUN,
      PCS_FLUSH,
      PCS_HALTED
   } pcseq_state_e;

   // True when the resolved control-transfer actually leaves the sequential path.
   function automatic logic takes_redirect(input logic [1:0] pcsrc, input logic taken);
      logic hit;
      hit = 1'b0;
      case (pcsrc)
         PCSRC_BRANCH: hit = taken;
         PCSRC_JAL,
         PCSRC_JALR:   hit = 1'b1;
         default:      hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Fetch/EX bus between the pipeline and pc_sequencer: EX redirect inputs plus the fetch-side PC.
interface pc_seq_if #(
   parameter int PC_W = 12
);
   logic            br_valid_EX;
   logic [1:0]      pcsrc_EX;
   logic            br_taken_EX;
   logic [PC_W-1:0] br_target_EX;
   logic [31:0]     jalr_target_EX;
   logic [31:0]     instr_F;
   logic [PC_W-1:0] pc;
   logic            flush_F;

   modport master (
      output br_valid_EX, pcsrc_EX, br_taken_EX, br_target_EX, jalr_target_EX, instr_F,
      input  pc, flush_F
   );

   modport slave (
      input  br_valid_EX, pcsrc_EX, br_taken_EX, br_target_EX, jalr_target_EX, instr_F,
      output pc, flush_F
   );
endinterface

// File: rtl/halt_detect.sv
// Counts consecutive unflushed, unstalled all-zero fetches and flags the one that completes the HALT idiom.
module halt_detect
   import cpu_pkg::*;
#(
   parameter int HALT_ZEROS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr_F,
   input  logic        flush_F,
   input  logic        stall_in,
   input  logic        clear,
   output logic        halt_hit
);

   logic [3:0] zero_cnt_q;
   logic [3:0] zero_cnt_d;
   logic       is_zero;
   logic       count_zero;

   always_comb begin
      is_zero    = (instr_F == INSTR_HALT);
      count_zero = !clear && !flush_F && is_zero && !stall_in;
      zero_cnt_d = zero_cnt_q;
      if (clear) begin
         zero_cnt_d = 4'd0;
      end else if (!flush_F) begin
         if (!is_zero) begin
            zero_cnt_d = 4'd0;
         end else if (!stall_in && zero_cnt_q != 4'd15) begin
            zero_cnt_d = zero_cnt_q + 4'd1;
         end
      end
      // Fire on the cycle the final zero is in F so the PC never advances past it.
      halt_hit = count_zero && (({1'b0, zero_cnt_q} + 5'd1) == 5'(HALT_ZEROS));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         zero_cnt_q <= 4'd0;
      end else begin
         zero_cnt_q <= zero_cnt_d;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: EX-stage redirects with a two-bubble squash, stall hold, HALT idiom detection.
// Optional performance counters are built when PC_SEQ_PERF_EN is defined.
module pc_sequencer
   import cpu_pkg::*;
#(
   parameter int              PC_W       = IMEM_AW,
   parameter logic [PC_W-1:0] RESET_PC   = '0,
   parameter int              HALT_ZEROS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_in,
   input  logic        resume,
   pc_seq_if.slave     bus,
   output logic        halted,
   output logic        misalign_err
`ifdef PC_SEQ_PERF_EN
   ,
   output logic [31:0] redirect_cnt,
   output logic [31:0] flush_cnt,
   output logic [31:0] stall_cnt
`endif
);

   pcseq_state_e    state_q;
   pcseq_state_e    state_d;
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] redirect_target;
   logic            misalign_q;
   logic            misalign_d;
   logic            redirect;
   logic            jalr_sel;
   logic            flush_F;
   logic            halt_hit;
   logic            hd_clear;
   logic            unused_jalr_hi;

   assign unused_jalr_hi = ^bus.jalr_target_EX[31:PC_W+2];

   // Redirect decode; branch inputs only count while running.
   always_comb begin
      jalr_sel        = (bus.pcsrc_EX == PCSRC_JALR);
      redirect        = (state_q == PCS_RUN) && bus.br_valid_EX
                        && takes_redirect(bus.pcsrc_EX, bus.br_taken_EX);
      redirect_target = jalr_sel ? bus.jalr_target_EX[PC_W+1:2] : bus.br_target_EX;
      pc_inc          = pc_q + PC_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= PCS_RUN;
         pc_q       <= RESET_PC;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
      end
   end

   // A redirect outranks both a stall and a completing halt idiom: the branch is older.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      misalign_d = 1'b0;
      case (state_q)
         PCS_RUN: begin
            if (redirect) begin
               state_d    = PCS_FLUSH;
               pc_d       = redirect_target;
               misalign_d = jalr_sel && (bus.jalr_target_EX[1:0] != 2'b00);
            end else if (halt_hit) begin
               state_d = PCS_HALTED;
            end else if (!stall_in) begin
               pc_d = pc_inc;
            end
         end
         PCS_FLUSH: begin
            state_d = PCS_RUN;
            if (!stall_in) begin
               pc_d = pc_inc;
            end
         end
         PCS_HALTED: begin
            if (resume) begin
               state_d = PCS_RUN;
               pc_d    = pc_inc;
            end
         end
         default: state_d = PCS_RUN;
      endcase
   end

   always_comb begin
      flush_F = 1'b0;
      halted  = 1'b0;
      case (state_q)
         PCS_RUN:    flush_F = redirect;
         PCS_FLUSH:  flush_F = 1'b1;
         PCS_HALTED: begin
            flush_F = 1'b1;
            halted  = 1'b1;
         end
         default:    flush_F = 1'b0;
      endcase
   end

   assign bus.pc       = pc_q;
   assign bus.flush_F  = flush_F;
   assign misalign_err = misalign_q;

   // The zero count restarts after any redirect and never advances outside RUN.
   assign hd_clear = redirect || (state_q != PCS_RUN);

   halt_detect #(
      .HALT_ZEROS (HALT_ZEROS)
   ) u_halt_detect (
      .clk      (clk),
      .rst      (rst),
      .instr_F  (bus.instr_F),
      .flush_F  (flush_F),
      .stall_in (stall_in),
      .clear    (hd_clear),
      .halt_hit (halt_hit)
   );

`ifdef PC_SEQ_PERF_EN
   logic [31:0] redirect_cnt_q;
   logic [31:0] redirect_cnt_d;
   logic [31:0] flush_cnt_q;
   logic [31:0] flush_cnt_d;
   logic [31:0] stall_cnt_q;
   logic [31:0] stall_cnt_d;

   always_comb begin
      redirect_cnt_d = redirect_cnt_q + {31'd0, redirect};
      flush_cnt_d    = flush_cnt_q + {31'd0, flush_F};
      stall_cnt_d    = stall_cnt_q + {31'd0, stall_in};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_cnt_q <= 32'd0;
         flush_cnt_q    <= 32'd0;
         stall_cnt_q    <= 32'd0;
      end else begin
         redirect_cnt_q <= redirect_cnt_d;
         flush_cnt_q    <= flush_cnt_d;
         stall_cnt_q    <= stall_cnt_d;
      end
   end

   assign redirect_cnt = redirect_cnt_q;
   assign flush_cnt    = flush_cnt_q;
   assign stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic, checked against a squash/zero-run model.
module tb_pc_sequencer;
   import cpu_pkg::*;

   localparam int              PC_W       = 12;
   localparam int              HALT_ZEROS = 2;
   localparam logic [PC_W-1:0] RESET_PC   = 12'h000;
   localparam logic [31:0]     NOP        = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst;
   logic stall_in;
   logic resume;
   logic halted;
   logic misalign_err;

   pc_seq_if #(.PC_W(PC_W)) bus ();

   pc_sequencer #(
      .PC_W       (PC_W),
      .RESET_PC   (RESET_PC),
      .HALT_ZEROS (HALT_ZEROS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stall_in     (stall_in),
      .resume       (resume),
      .bus          (bus),
      .halted       (halted),
      .misalign_err (misalign_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   // Model: current PC, bubbles still owed after a redirect, halt flag, zero run length.
   int m_pc;
   int m_squash;
   bit m_halted;
   int m_zeros;
   bit m_misalign;

   function automatic bit wantsRedirect();
      if (m_halted || m_squash > 0 || !bus.br_valid_EX) return 1'b0;
      if (bus.pcsrc_EX == 2'b10 || bus.pcsrc_EX == 2'b11) return 1'b1;
      if (bus.pcsrc_EX == 2'b01) return bus.br_taken_EX;
      return 1'b0;
   endfunction

   function automatic int targetOf();
      if (bus.pcsrc_EX == 2'b11) return int'(bus.jalr_target_EX / 4) % 4096;
      return int'(bus.br_target_EX);
   endfunction

   task automatic modelReset();
      m_pc       = int'(RESET_PC);
      m_squash   = 0;
      m_halted   = 1'b0;
      m_zeros    = 0;
      m_misalign = 1'b0;
   endtask

   task automatic modelAdvance();
      bit redir;
      bit hit;
      int tgt;
      redir = wantsRedirect();
      tgt   = targetOf();
      hit   = 1'b0;
      if (rst) begin
         modelReset();
         return;
      end
      m_misalign = 1'b0;
      if (m_halted) begin
         if (resume) begin
            m_halted = 1'b0;
            m_zeros  = 0;
            m_pc     = (m_pc + 1) % 4096;
         end
      end else if (m_squash > 0) begin
         m_squash = m_squash - 1;
         if (!stall_in) m_pc = (m_pc + 1) % 4096;
      end else if (redir) begin
         m_pc       = tgt;
         m_squash   = 1;
         m_zeros    = 0;
         m_misalign = (bus.pcsrc_EX == 2'b11) && (bus.jalr_target_EX % 4 != 0);
      end else begin
         if (bus.instr_F != 32'd0) begin
            m_zeros = 0;
         end else if (!stall_in) begin
            m_zeros = (m_zeros < 15) ? m_zeros + 1 : 15;
            hit     = (m_zeros == HALT_ZEROS);
         end
         if (hit) m_halted = 1'b1;
         else if (!stall_in) m_pc = (m_pc + 1) % 4096;
      end
   endtask

   task automatic checkOne(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask

   task automatic checkOutput(input string step);
      bit exp_flush;
      exp_flush = m_halted || (m_squash > 0) || wantsRedirect();
      checkOne({step, " pc"},       32'(bus.pc),       32'(m_pc));
      checkOne({step, " flush_F"},  32'(bus.flush_F),  32'(exp_flush));
      checkOne({step, " halted"},   32'(halted),       32'(m_halted));
      checkOne({step, " misalign"}, 32'(misalign_err), 32'(m_misalign));
   endtask

   // Drive one cycle of inputs, check at the falling edge, then step the model with the clock.
   task automatic applyStimulus(input bit r, input bit s, input logic [31:0] instr,
                                input bit bv, input logic [1:0] src, input bit tk,
                                input logic [11:0] bt, input logic [31:0] jt,
                                input bit res, input string step);
      rst                = r;
      stall_in           = s;
      bus.instr_F        = instr;
      bus.br_valid_EX    = bv;
      bus.pcsrc_EX       = src;
      bus.br_taken_EX    = tk;
      bus.br_target_EX   = bt;
      bus.jalr_target_EX = jt;
      resume             = res;
      @(negedge clk);
      checkOutput(step);
      modelAdvance();
      @(posedge clk);
      #1;
   endtask

   task automatic seqStep(input logic [31:0] instr, input bit s, input string step);
      applyStimulus(1'b0, s, instr, 1'b0, 2'b00, 1'b0, 12'h000, 32'h0, 1'b0, step);
   endtask

   task automatic redirectStep(input logic [1:0] src, input logic [11:0] bt,
                               input logic [31:0] jt, input bit s, input string step);
      applyStimulus(1'b0, s, NOP, 1'b1, src, 1'b1, bt, jt, 1'b0, step);
   endtask

   initial begin
      rst = 1'b1; stall_in = 1'b0; resume = 1'b0;
      bus.instr_F = NOP; bus.br_valid_EX = 1'b0; bus.pcsrc_EX = 2'b00;
      bus.br_taken_EX = 1'b0; bus.br_target_EX = 12'h000; bus.jalr_target_EX = 32'h0;
      @(posedge clk);
      #1;
      modelReset();

      applyStimulus(1'b1, 1'b0, NOP, 1'b0, 2'b00, 1'b0, 12'h000, 32'h0, 1'b0, "reset");

      for (int i = 0; i < 16; i++) begin
         checkOne("seq pc const", 32'(bus.pc), 32'(i));
         seqStep(NOP, 1'b0, "seq");
      end

      redirectStep(2'b01, 12'h040, 32'h0, 1'b0, "branch");
      checkOne("branch target", 32'(bus.pc), 32'h040);
      checkOne("branch flush2", 32'(bus.flush_F), 32'h1);
      seqStep(NOP, 1'b0, "branch flush");
      checkOne("branch next", 32'(bus.pc), 32'h041);

      redirectStep(2'b11, 12'h000, 32'h0000_0106, 1'b0, "jalr");
      checkOne("jalr target", 32'(bus.pc), 32'h041);
      checkOne("jalr misalign", 32'(misalign_err), 32'h1);
      seqStep(NOP, 1'b0, "jalr flush");
      checkOne("jalr misalign end", 32'(misalign_err), 32'h0);

      redirectStep(2'b10, 12'h01F, 32'h0, 1'b0, "jal to 1f");
      seqStep(NOP, 1'b0, "jal flush");
      checkOne("stall start pc", 32'(bus.pc), 32'h020);
      seqStep(NOP, 1'b1, "stall1");
      checkOne("stall hold", 32'(bus.pc), 32'h020);
      redirectStep(2'b10, 12'h100, 32'h0, 1'b1, "stall2 jal");
      checkOne("stall jal wins", 32'(bus.pc), 32'h100);
      seqStep(NOP, 1'b1, "stall3 flush");
      seqStep(NOP, 1'b0, "after stall");

      seqStep(32'h0, 1'b0, "zero1");
      seqStep(32'h0, 1'b0, "zero2");
      checkOne("halt entered", 32'(halted), 32'h1);
      checkOne("halt pc frozen", 32'(bus.pc), 32'h102);
      seqStep(32'h0, 1'b1, "halted idle");
      applyStimulus(1'b0, 1'b0, NOP, 1'b1, 2'b10, 1'b1, 12'h300, 32'h0, 1'b0, "halted branch");
      applyStimulus(1'b0, 1'b0, NOP, 1'b0, 2'b00, 1'b0, 12'h000, 32'h0, 1'b1, "resume");
      checkOne("resume pc", 32'(bus.pc), 32'h103);
      checkOne("resume halted", 32'(halted), 32'h0);

      redirectStep(2'b10, 12'hFFF, 32'h0, 1'b0, "jal to fff");
      seqStep(NOP, 1'b0, "wrap");
      checkOne("wrap pc", 32'(bus.pc), 32'h000);
      redirectStep(2'b10, 12'h123, 32'h0, 1'b0, "jal to 123");
      applyStimulus(1'b1, 1'b0, NOP, 1'b0, 2'b00, 1'b0, 12'h000, 32'h0, 1'b0, "rst in flush");
      checkOne("rst flush pc", 32'(bus.pc), 32'(RESET_PC));
      checkOne("rst flush flush_F", 32'(bus.flush_F), 32'h0);

      seqStep(32'h0, 1'b0, "zero1b");
      seqStep(32'h0, 1'b0, "zero2b");
      applyStimulus(1'b1, 1'b0, NOP, 1'b0, 2'b00, 1'b0, 12'h000, 32'h0, 1'b0, "rst in halt");
      checkOne("rst halt halted", 32'(halted), 32'h0);

      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 99) < 2),
                       ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom,
                       ($urandom_range(0, 3) == 0),
                       2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)),
                       12'($urandom),
                       $urandom,
                       ($urandom_range(0, 2) == 0),
                       "random");
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
